// File: rtl/my_video_pkg.sv
// Shared types and constants for the pixel fetch path: source modes, FSM states,
// colour-bar palette and RGB565 expansion.
package my_video_pkg;

    typedef enum logic [1:0] {
        MODE_IMG   = 2'd0,
        MODE_BAR   = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HBLANK = 2'd1,
        S_LINE   = 2'd2
    } state_t;

    localparam int CNT_W = 12;

    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Replicate the top bits into the low bits so full-scale maps to 0xFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/my_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
module my_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [WIDTH-1:0] I_d,
    output logic [WIDTH-1:0] O_q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] r_q;
            logic [WIDTH-1:0] w_d;
            if (gi == 0) begin : g_src
                assign w_d = I_d;
            end else begin : g_src
                assign w_d = g_stage[gi-1].r_q;
            end
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) r_q <= '0;
                else          r_q <= w_d;
            end
        end
    endgenerate

    assign O_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/my_pixel_fetch.sv
// Turns timing-generator DE/HS/VS into aligned RGB888, sourcing pixels from an
// up-scaled RGB565 frame store or from internal test patterns.
module my_pixel_fetch
    import my_video_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int PIX_W       = 16,
    parameter int RAM_LATENCY = 2,
    parameter int SCALE_SHIFT = 2,
    parameter int BAR_SHIFT   = 7
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    input  logic [1:0]        I_mode,
    input  logic [23:0]       I_solid_rgb,
    input  logic [11:0]       I_img_w,
    input  logic [11:0]       I_img_h,
    input  logic              I_de,
    input  logic              I_hs,
    input  logic              I_vs,
    output logic              O_ram_ce,
    output logic [ADDR_W-1:0] O_ram_addr,
    input  logic [PIX_W-1:0]  I_ram_dout,
    output logic              O_de,
    output logic              O_hs,
    output logic              O_vs,
    output logic [7:0]        O_r,
    output logic [7:0]        O_g,
    output logic [7:0]        O_b,
    output logic              O_frame_start
);

    localparam logic [CNT_W-1:0] SCALE_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

    logic              r_de_q, r_vs_q;
    logic              w_vs_rise, w_de_rise, w_de_fall;
    state_t            r_state, w_state_next;
    mode_t             r_mode, w_mode;
    logic [CNT_W-1:0]  r_x_cnt, r_line_cnt, w_line;
    logic [ADDR_W-1:0] r_line_base, w_base, w_addr;
    logic [CNT_W-1:0]  w_src_x, w_src_y;
    logic              w_active, w_in_img;
    logic [2:0]        w_bar_idx;
    logic [23:0]       w_pattern;

    logic              r_ram_ce;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_s1_active, r_s1_hs, r_s1_vs, r_s1_in_img;
    logic [23:0]       r_s1_pattern;
    logic              r_frame_start;

    logic              w_d_active, w_d_hs, w_d_vs, w_d_in_img;
    logic [23:0]       w_d_pattern;
    logic              r_de, r_hs, r_vs;
    logic [23:0]       r_rgb;

    assign w_vs_rise = I_vs & ~r_vs_q;
    assign w_de_rise = I_de & ~r_de_q;
    assign w_de_fall = ~I_de & r_de_q;

    // The vs_rise cycle already belongs to the new frame.
    assign w_mode = w_vs_rise ? mode_t'(I_mode) : r_mode;
    assign w_line = w_vs_rise ? '0 : r_line_cnt;
    assign w_base = w_vs_rise ? '0 : r_line_base;

    assign w_src_x = r_x_cnt >> SCALE_SHIFT;
    assign w_src_y = w_line >> SCALE_SHIFT;
    assign w_addr  = w_base + ADDR_W'(w_src_x);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_de_q  <= 1'b0;
            r_vs_q  <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            r_de_q  <= I_de;
            r_vs_q  <= I_vs;
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_IDLE;
            S_HBLANK: if (w_de_rise) w_state_next = S_LINE;
            S_LINE:   if (w_de_fall) w_state_next = S_HBLANK;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_vs_rise) w_state_next = w_de_rise ? S_LINE : S_HBLANK;
        // DE is suppressed until a frame has been seen since reset.
        w_active = I_de & ((r_state != S_IDLE) | w_vs_rise);
        w_in_img = (w_mode == MODE_IMG) & w_active &
                   (w_src_x < I_img_w) & (w_src_y < I_img_h);
    end

    // Line base steps by one stored row every 2^SCALE_SHIFT output lines.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_x_cnt     <= '0;
            r_line_cnt  <= '0;
            r_line_base <= '0;
            r_mode      <= MODE_IMG;
        end else begin
            r_x_cnt <= I_de ? r_x_cnt + 1'b1 : '0;
            if (w_vs_rise) begin
                r_line_cnt  <= '0;
                r_line_base <= '0;
                r_mode      <= mode_t'(I_mode);
            end else if (w_de_fall) begin
                r_line_cnt <= r_line_cnt + 1'b1;
                if ((r_line_cnt & SCALE_MASK) == SCALE_MASK)
                    r_line_base <= r_line_base + ADDR_W'(I_img_w);
            end
        end
    end

    always_comb begin
        w_bar_idx = 3'(r_x_cnt >> BAR_SHIFT);
        w_pattern = I_solid_rgb;
        case (w_mode)
            MODE_BAR:  w_pattern = BAR_RGB[w_bar_idx];
            MODE_GRID: w_pattern = (r_x_cnt[4:0] == 5'd0 || w_line[4:0] == 5'd0)
                                   ? 24'hFFFFFF : 24'h000000;
            default:   w_pattern = I_solid_rgb;
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_ram_ce      <= 1'b0;
            r_ram_addr    <= '0;
            r_s1_active   <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
            r_s1_in_img   <= 1'b0;
            r_s1_pattern  <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_ram_ce      <= w_in_img;
            if (w_in_img) r_ram_addr <= w_addr;
            r_s1_active   <= w_active;
            r_s1_hs       <= I_hs;
            r_s1_vs       <= I_vs;
            r_s1_in_img   <= w_in_img;
            r_s1_pattern  <= w_pattern;
            r_frame_start <= w_vs_rise;
        end
    end

    // Both bundles wait out the RAM read so every mode shares one latency.
    my_delay_line #(.WIDTH(3), .DEPTH(RAM_LATENCY)) u_sync_dly (
        .I_clk   (I_pxl_clk),
        .I_rst_n (I_rst_n),
        .I_d     ({r_s1_active, r_s1_hs, r_s1_vs}),
        .O_q     ({w_d_active, w_d_hs, w_d_vs})
    );

    my_delay_line #(.WIDTH(25), .DEPTH(RAM_LATENCY)) u_pix_dly (
        .I_clk   (I_pxl_clk),
        .I_rst_n (I_rst_n),
        .I_d     ({r_s1_in_img, r_s1_pattern}),
        .O_q     ({w_d_in_img, w_d_pattern})
    );

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_de  <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_rgb <= '0;
        end else begin
            r_de <= w_d_active;
            r_hs <= w_d_hs;
            r_vs <= w_d_vs;
            if (!w_d_active)     r_rgb <= '0;
            else if (w_d_in_img) r_rgb <= rgb565_to_888(I_ram_dout[15:0]);
            else                 r_rgb <= w_d_pattern;
        end
    end

    assign O_ram_ce      = r_ram_ce;
    assign O_ram_addr    = r_ram_addr;
    assign O_de          = r_de;
    assign O_hs          = r_hs;
    assign O_vs          = r_vs;
    assign O_r           = r_rgb[23:16];
    assign O_g           = r_rgb[15:8];
    assign O_b           = r_rgb[7:0];
    assign O_frame_start = r_frame_start;

endmodule

// File: tb/tb_my_pixel_fetch.sv
// Directed bench for my_pixel_fetch with a 2-cycle-latency frame-store model.
module tb_my_pixel_fetch;

    logic        I_pxl_clk = 1'b0;
    logic        I_rst_n   = 1'b0;
    logic [1:0]  I_mode    = 2'd1;
    logic [23:0] I_solid_rgb = 24'h123456;
    logic [11:0] I_img_w   = 12'd200;
    logic [11:0] I_img_h   = 12'd150;
    logic        I_de = 1'b0, I_hs = 1'b0, I_vs = 1'b0;
    logic        O_ram_ce;
    logic [15:0] O_ram_addr;
    logic [15:0] I_ram_dout = 16'h0;
    logic        O_de, O_hs, O_vs, O_frame_start;
    logic [7:0]  O_r, O_g, O_b;

    int n_err = 0;
    int n_checks = 0;

    always #5 I_pxl_clk = ~I_pxl_clk;

    my_pixel_fetch dut (
        .I_pxl_clk     (I_pxl_clk),
        .I_rst_n       (I_rst_n),
        .I_mode        (I_mode),
        .I_solid_rgb   (I_solid_rgb),
        .I_img_w       (I_img_w),
        .I_img_h       (I_img_h),
        .I_de          (I_de),
        .I_hs          (I_hs),
        .I_vs          (I_vs),
        .O_ram_ce      (O_ram_ce),
        .O_ram_addr    (O_ram_addr),
        .I_ram_dout    (I_ram_dout),
        .O_de          (O_de),
        .O_hs          (O_hs),
        .O_vs          (O_vs),
        .O_r           (O_r),
        .O_g           (O_g),
        .O_b           (O_b),
        .O_frame_start (O_frame_start)
    );

    // Frame store: a few hand-picked words, otherwise data equals address.
    function automatic logic [15:0] ram_val(input logic [15:0] a);
        case (a)
            16'd0:   return 16'hF800;
            16'd1:   return 16'h07E0;
            16'd2:   return 16'h0010;
            default: return a;
        endcase
    endfunction

    logic [15:0] ram_p1 = 16'h0;
    always @(posedge I_pxl_clk) begin
        if (O_ram_ce) ram_p1 <= ram_val(O_ram_addr);
        I_ram_dout <= ram_p1;
    end

    // Capture of output pixels, RAM addresses and edge times per line.
    int cyc = 0;
    always @(posedge I_pxl_clk) cyc <= cyc + 1;

    logic [23:0] cap_rgb  [1024];
    logic [15:0] cap_addr [1024];
    int cap_idx = 0, addr_idx = 0;
    int n_ode = 0, n_ce = 0, n_fs = 0;
    int t_de_in = 0, t_de_out = 0, t_hs_in = 0, t_hs_out = 0;
    logic prev_ode = 1'b0, prev_ide = 1'b0, prev_ihs = 1'b0, prev_ohs = 1'b0;

    always @(negedge I_pxl_clk) begin
        if (I_de && !prev_ide) begin t_de_in = cyc; addr_idx = 0; end
        if (I_hs && !prev_ihs) t_hs_in = cyc;
        if (O_hs && !prev_ohs) t_hs_out = cyc;
        if (O_de && !prev_ode) begin t_de_out = cyc; cap_idx = 0; end
        if (O_de) begin
            if (cap_idx < 1024) cap_rgb[cap_idx] = {O_r, O_g, O_b};
            cap_idx++;
            n_ode++;
        end
        if (O_ram_ce) begin
            if (addr_idx < 1024) cap_addr[addr_idx] = O_ram_addr;
            addr_idx++;
            n_ce++;
        end
        if (O_frame_start) n_fs++;
        prev_ide = I_de;
        prev_ihs = I_hs;
        prev_ohs = O_hs;
        prev_ode = O_de;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge I_pxl_clk);
        #1;
    endtask

    task automatic drive_line(input int n_de);
        I_de = 1'b1; tick(n_de);
        I_de = 1'b0; I_hs = 1'b1; tick(4);
        I_hs = 1'b0; tick(12);
    endtask

    task automatic vsync();
        I_vs = 1'b1; tick(3);
        I_vs = 1'b0; tick(5);
    endtask

    int base_ode, base_ce, base_fs;

    initial begin
        // Reset held while syncs toggle.
        for (int i = 0; i < 12; i++) begin
            I_de = i[0]; I_vs = i[1]; I_hs = i[2];
            tick(1);
        end
        check("rst_outs", {3'b0, O_de, O_hs, O_vs, O_ram_ce, O_frame_start, O_r, O_g, O_b}, 32'h0);
        check("rst_addr", {16'h0, O_ram_addr}, 32'h0);
        check("rst_fs", n_fs, 0);
        I_de = 1'b0; I_vs = 1'b0; I_hs = 1'b0;
        tick(2);
        I_rst_n = 1'b1;
        tick(2);

        base_ode = n_ode;
        drive_line(64);
        check("no_de_before_vs", n_ode - base_ode, 0);

        // Colour bars.
        base_fs = n_fs;
        vsync();
        check("fs_once", n_fs - base_fs, 1);
        base_ode = n_ode; base_ce = n_ce;
        drive_line(1024);
        check("bar_de_latency", t_de_out - t_de_in, 4);
        check("bar_hs_latency", t_hs_out - t_hs_in, 4);
        check("bar_de_count", n_ode - base_ode, 1024);
        check("bar_no_ce", n_ce - base_ce, 0);
        check("bar_px0", cap_rgb[0], 24'hFFFFFF);
        check("bar_px127", cap_rgb[127], 24'hFFFFFF);
        check("bar_px128", cap_rgb[128], 24'hFFFF00);
        check("bar_px300", cap_rgb[300], 24'h00FFFF);
        check("bar_px1023", cap_rgb[1023], 24'h000000);

        // Mode change mid-frame waits for the next frame.
        I_mode = 2'd3;
        drive_line(1024);
        check("switch_hold_px128", cap_rgb[128], 24'hFFFF00);
        check("switch_hold_px700", cap_rgb[700], 24'hFF0000);
        vsync();
        drive_line(256);
        check("solid_px5", cap_rgb[5], 24'h123456);

        // Grid.
        I_mode = 2'd2;
        vsync();
        drive_line(64);
        check("grid_l0_px1", cap_rgb[1], 24'hFFFFFF);
        drive_line(64);
        check("grid_l1_px0", cap_rgb[0], 24'hFFFFFF);
        check("grid_l1_px1", cap_rgb[1], 24'h000000);
        check("grid_l1_px32", cap_rgb[32], 24'hFFFFFF);
        check("grid_l1_px33", cap_rgb[33], 24'h000000);

        // Frame-store image, 200x150 up-scaled by 4.
        I_mode = 2'd0;
        vsync();
        base_ce = n_ce;
        drive_line(1024);
        check("img_l0_ce_count", n_ce - base_ce, 800);
        check("img_l0_addr0", cap_addr[0], 0);
        check("img_l0_addr3", cap_addr[3], 0);
        check("img_l0_addr4", cap_addr[4], 1);
        check("img_l0_addr799", cap_addr[799], 199);
        check("img_px0_red", cap_rgb[0], 24'hFF0000);
        check("img_px4_green", cap_rgb[4], 24'h00FF00);
        check("img_px8_blue", cap_rgb[8], 24'h000084);
        check("img_px12", cap_rgb[12], 24'h000018);
        check("img_px800_border", cap_rgb[800], 24'h123456);
        check("img_px1023_border", cap_rgb[1023], 24'h123456);
        drive_line(1024);
        drive_line(1024);
        drive_line(1024);
        check("img_l3_addr0", cap_addr[0], 0);
        check("img_l3_addr4", cap_addr[4], 1);
        drive_line(1024);
        check("img_l4_addr0", cap_addr[0], 200);
        check("img_l4_addr4", cap_addr[4], 201);
        check("img_l4_px0", cap_rgb[0], 24'h001842);

        // Vertical image boundary with a one-line image.
        I_img_h = 12'd1;
        vsync();
        drive_line(64); drive_line(64); drive_line(64);
        base_ce = n_ce;
        drive_line(64);
        check("vb_l3_ce_count", n_ce - base_ce, 64);
        base_ce = n_ce;
        drive_line(64);
        check("vb_l4_ce_count", n_ce - base_ce, 0);
        check("vb_l4_px0", cap_rgb[0], 24'h123456);

        // Asynchronous reset in the middle of a line.
        I_mode = 2'd1;
        vsync();
        I_de = 1'b1;
        tick(100);
        @(negedge I_pxl_clk);
        check("pre_rst_de", {31'h0, O_de}, 1);
        I_rst_n = 1'b0;
        #1;
        check("async_rst_de", {31'h0, O_de}, 0);
        check("async_rst_rgb", {O_r, O_g, O_b}, 24'h0);
        tick(3);
        I_rst_n = 1'b1;
        base_ode = n_ode;
        tick(50);
        I_de = 1'b0;
        tick(16);
        drive_line(64);
        check("no_de_after_rst", n_ode - base_ode, 0);
        vsync();
        drive_line(64);
        check("de_after_vs", n_ode - base_ode, 64);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
